alu_stage: RTL and testbench
============================

# alu_stage

Execute-stage ALU for the SimpleRISC pipeline. It consumes the operands and one-hot control word held in the OF/ALU pipeline register and produces the result and handshake consumed by the ALU/MA register. Single-cycle operations complete combinationally. Signed `div`/`mod` run on an iterative 32-step divider that stalls the OF/ALU register (`stall_OFALU`) until the quotient or remainder is ready. The block also owns the architectural compare flags (`flags_E`, `flags_GT`) written by `cmp`.

## Interface
- No parameters; data width fixed at 32.
- `clk` — input, 1 — rising-edge clock; the only clock.
- `reset` — input, 1 — synchronous, active-high reset.
- `valid_ALU` — input, 1 — the OF/ALU register holds a real instruction (not a bubble).
- `aluSignals_ALU` — input, 13 — one-hot op select:
  - bits 0–5: add, sub, cmp, mul, div, mod
  - bits 6–12: lsl, lsr, asr, or, and, not, mov
- `A_ALU` — input, 32 — operand 1.
- `B_ALU` — input, 32 — operand 2 (immediate already selected upstream).
- `aluResult` — output, 32 — result; meaningful only while `res_valid` = 1.
- `res_valid` — output, 1 — `aluResult` is valid this cycle.
- `stall_OFALU` — output, 1 — holds the OF/ALU register while high.
- `flags_E` — output, 1 — registered flag: last cmp found equal.
- `flags_GT` — output, 1 — registered flag: last cmp found A > B (signed).

## Operation
- **Op decode:** if more than one control bit is set, the lowest set index wins. All-zero is a nop: `aluResult` = 0 and `res_valid` = `valid_ALU`.
- **Single-cycle op results** (all arithmetic mod 2^32):
  - add: A+B
  - sub: A−B
  - cmp: `aluResult` = 0
  - mul: low 32 bits of the signed product
  - lsl / lsr / asr: shift A by B[4:0]; asr is arithmetic
  - or / and: bitwise A|B, A&B
  - not: ~B
  - mov: B
- **Flags:** on a clock edge with `valid_ALU`, cmp selected and state IDLE:
  - `flags_E` <= (A == B)
  - `flags_GT` <= ($signed(A) > $signed(B))
  - No other op touches the flags.
- **Divider FSM, states IDLE, DIV, DONE:**
  - **IDLE:** single-cycle ops are not stalled.
    - On `valid_ALU` with div or mod selected: latch |A|, |B| (as unsigned 32-bit), sign(A), sign(A)^sign(B) and the op.
    - Clear the step counter, go to DIV.
    - If B == 0, go straight to DONE instead.
  - **DIV:** one restoring step per cycle (shift remainder/quotient, trial-subtract, set quotient bit). After step 32 (counter == 31), go to DONE.
  - **DONE:** drive the registered result, then return to IDLE.
- **Division results:**
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of A.
  - 0x80000000 / −1 gives quotient 0x80000000, remainder 0; this falls out of unsigned magnitudes with no special case.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = A.
- **Handshake signals:**
  - `stall_OFALU` = (IDLE & `valid_ALU` & divop) | DIV.
  - `res_valid` = (IDLE & `valid_ALU` & ~divop) | DONE.
  - In DONE, `aluResult` is the registered quotient or remainder.
- **Operand hold:** upstream holds A, B and the control word while stalled. The block still uses only the latched copies during DIV/DONE.

## Timing
- **Reset:** registered state after reset:
  - State IDLE, counter 0, quotient and remainder registers 0.
  - `flags_E` = `flags_GT` = 0.
  - While `reset` is high, `stall_OFALU` and `res_valid` are forced to 0.
- **Reset mid-divide:** abandons the division. IDLE, stall low and flags 0 on the next cycle; no `res_valid` pulse.
- **Single-cycle ops:** zero latency; result in the same cycle the OF/ALU register presents the op.
- **div/mod, B ≠ 0:** op presented in cycle 0.
  - DIV occupies cycles 1–32; DONE is cycle 33.
  - `stall_OFALU` is high for cycles 0–32 (33 cycles) and low in cycle 33.
  - `res_valid` is high only in cycle 33; OF/ALU advances at the end of cycle 33.
- **div/mod, B = 0:** stall high in cycle 0 only; DONE in cycle 1.
- **Back-to-back div:** the next div is seen in IDLE in cycle 34 and restarts the sequence; no extra bubble.
- **Bubbles:** `valid_ALU` = 0 in IDLE gives no stall, no flag write and `res_valid` = 0.

## Test plan
- add 5+7, then asr 0x80000000 by 4: `aluResult` 12, then 0xF8000000. `res_valid` = 1 and stall 0 in both cycles.
- cmp (−3, 2), then cmp (7, 7):
  - After the first edge: E = 0, GT = 0.
  - After the second: E = 1, GT = 0.
  - A following add leaves the flags unchanged.
- div −7/2:
  - Stall high exactly 33 cycles; `res_valid` in cycle 33 with 0xFFFFFFFD.
  - Repeat as mod: 0xFFFFFFFF.
  - Back-to-back pair: second result at cycle 67.
- div 10/0 → stall 1 cycle, 0xFFFFFFFF in cycle 1; mod 10/0 → 10.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000; mod → 0.
- Assert reset in cycle 10 of a div:
  - Next cycle: stall 0, `res_valid` 0, flags 0.
  - A subsequent add 1+1 returns 2 with no stall.

Source files
------------

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - SimpleRISC execute-stage ALU with iterative signed div/mod and compare flags
module alu_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ALU,
    input  logic [12:0] aluSignals_ALU,
    input  logic [31:0] A_ALU,
    input  logic [31:0] B_ALU,
    output logic [31:0] aluResult,
    output logic        res_valid,
    output logic        stall_OFALU,
    output logic        flags_E,
    output logic        flags_GT
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [12:0] sel;
    logic        divop;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] single_res;
    logic [31:0] div_res;

    logic [31:0] dvs_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [4:0]  cnt_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        is_mod_r;

    logic [32:0] shifted;
    logic [32:0] diff;

    // Isolating the lowest set bit gives lowest-index-wins priority for free.
    assign sel   = aluSignals_ALU & (~aluSignals_ALU + 13'd1);
    assign divop = sel[4] | sel[5];
    assign abs_a = A_ALU[31] ? (~A_ALU + 32'd1) : A_ALU;
    assign abs_b = B_ALU[31] ? (~B_ALU + 32'd1) : B_ALU;

    // Restoring step: quo_r starts as the dividend and shifts quotient bits in from the right.
    assign shifted = {rem_r, quo_r[31]};
    assign diff    = shifted - {1'b0, dvs_r};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (valid_ALU && divop) begin
                    state_nxt = (B_ALU == 32'd0) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (cnt_r == 5'd31) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvs_r    <= 32'd0;
            quo_r    <= 32'd0;
            rem_r    <= 32'd0;
            cnt_r    <= 5'd0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_mod_r <= 1'b0;
            flags_E  <= 1'b0;
            flags_GT <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_ALU && sel[2]) begin
                        flags_E  <= (A_ALU == B_ALU);
                        flags_GT <= ($signed(A_ALU) > $signed(B_ALU));
                    end
                    if (valid_ALU && divop) begin
                        dvs_r    <= abs_b;
                        cnt_r    <= 5'd0;
                        neg_r_r  <= A_ALU[31];
                        is_mod_r <= sel[5];
                        if (B_ALU == 32'd0) begin
                            // Remainder re-signed by A's sign reproduces A exactly.
                            quo_r   <= 32'hFFFF_FFFF;
                            rem_r   <= abs_a;
                            neg_q_r <= 1'b0;
                        end else begin
                            quo_r   <= abs_a;
                            rem_r   <= 32'd0;
                            neg_q_r <= A_ALU[31] ^ B_ALU[31];
                        end
                    end
                end
                S_DIV: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (!diff[32]) begin
                        rem_r <= diff[31:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= shifted[31:0];
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        single_res = 32'd0;
        if (sel[0])       single_res = A_ALU + B_ALU;
        else if (sel[1])  single_res = A_ALU - B_ALU;
        else if (sel[2])  single_res = 32'd0;
        else if (sel[3])  single_res = A_ALU * B_ALU;
        else if (sel[6])  single_res = A_ALU << B_ALU[4:0];
        else if (sel[7])  single_res = A_ALU >> B_ALU[4:0];
        else if (sel[8])  single_res = $signed(A_ALU) >>> B_ALU[4:0];
        else if (sel[9])  single_res = A_ALU | B_ALU;
        else if (sel[10]) single_res = A_ALU & B_ALU;
        else if (sel[11]) single_res = ~B_ALU;
        else if (sel[12]) single_res = B_ALU;
    end

    always_comb begin
        div_res = 32'd0;
        if (is_mod_r) begin
            div_res = neg_r_r ? (~rem_r + 32'd1) : rem_r;
        end else begin
            div_res = neg_q_r ? (~quo_r + 32'd1) : quo_r;
        end
    end

    always_comb begin
        stall_OFALU = 1'b0;
        res_valid   = 1'b0;
        aluResult   = 32'd0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    stall_OFALU = valid_ALU & divop;
                    res_valid   = valid_ALU & ~divop;
                    aluResult   = single_res;
                end
                S_DIV: stall_OFALU = 1'b1;
                S_DONE: begin
                    res_valid = 1'b1;
                    aluResult = div_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - scoreboard bench for alu_stage
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ALU;
    logic [12:0] aluSignals_ALU;
    logic [31:0] A_ALU;
    logic [31:0] B_ALU;
    logic [31:0] aluResult;
    logic        res_valid;
    logic        stall_OFALU;
    logic        flags_E;
    logic        flags_GT;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_CMP = 2, OP_MUL = 3, OP_DIV = 4, OP_MOD = 5;
    localparam int OP_LSL = 6, OP_LSR = 7, OP_ASR = 8, OP_OR = 9, OP_AND = 10, OP_NOT = 11, OP_MOV = 12;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    alu_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_ALU      (valid_ALU),
        .aluSignals_ALU (aluSignals_ALU),
        .A_ALU          (A_ALU),
        .B_ALU          (B_ALU),
        .aluResult      (aluResult),
        .res_valid      (res_valid),
        .stall_OFALU    (stall_OFALU),
        .flags_E        (flags_E),
        .flags_GT       (flags_GT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] op(input int k);
        logic [12:0] one;
        one = 13'd1;
        return one << k;
    endfunction

    always @(negedge clk) begin
        if (!reset && res_valid) begin
            if (q.size() == 0) begin
                check("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, aluResult, e.val);
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Caller is positioned just after a rising edge; returns likewise one cycle later.
    task automatic single(input logic [12:0] sig, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        valid_ALU = 1'b1; aluSignals_ALU = sig; A_ALU = a; B_ALU = b;
        q.push_back('{exp, cyc, name});
        @(negedge clk);
        check({name, "_stall"}, {31'd0, stall_OFALU}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic div_op(input logic [12:0] sig, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int n;
        valid_ALU = 1'b1; aluSignals_ALU = sig; A_ALU = a; B_ALU = b;
        q.push_back('{exp, cyc + lat, name});
        n = 0;
        @(negedge clk);
        while (stall_OFALU && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, n, lat);
        check({name, "_rv_after_stall"}, {31'd0, res_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic bubble();
        valid_ALU = 1'b0; aluSignals_ALU = op(OP_ADD); A_ALU = 32'd1; B_ALU = 32'd1;
        @(negedge clk);
        check("bubble_stall", {31'd0, stall_OFALU}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; valid_ALU = 1'b0; aluSignals_ALU = 13'd0; A_ALU = 32'd0; B_ALU = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        valid_ALU = 1'b1; aluSignals_ALU = op(OP_DIV); A_ALU = 32'd9; B_ALU = 32'd3;
        @(negedge clk);
        check("reset_stall_forced", {31'd0, stall_OFALU}, 32'd0);
        check("reset_rv_forced", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; valid_ALU = 1'b0;
        @(negedge clk);
        check("reset_flags_E", {31'd0, flags_E}, 32'd0);
        check("reset_flags_GT", {31'd0, flags_GT}, 32'd0);
        check("reset_idle_stall", {31'd0, stall_OFALU}, 32'd0);
        @(posedge clk); #1;

        single(op(OP_ADD), 32'd5, 32'd7, 32'd12, "add_5_7");
        single(op(OP_ASR), 32'h8000_0000, 32'd4, 32'hF800_0000, "asr");
        single(op(OP_SUB), 32'd3, 32'd5, 32'hFFFF_FFFE, "sub");
        single(op(OP_MUL), 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "mul");
        single(op(OP_LSL), 32'd1, 32'd33, 32'd2, "lsl_b40");
        single(op(OP_LSR), 32'h8000_0000, 32'd4, 32'h0800_0000, "lsr");
        single(op(OP_OR), 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or");
        single(op(OP_AND), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, "and");
        single(op(OP_NOT), 32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_0000, "not");
        single(op(OP_MOV), 32'h1111_1111, 32'hCAFE_BABE, 32'hCAFE_BABE, "mov");
        single(13'd0, 32'd5, 32'd6, 32'd0, "nop");
        single(op(OP_ADD) | op(OP_SUB), 32'd5, 32'd6, 32'd11, "prio_add_over_sub");
        single(op(OP_SUB) | op(OP_MOV), 32'd5, 32'd6, 32'hFFFF_FFFF, "prio_sub_over_mov");
        bubble();

        single(op(OP_CMP), 32'hFFFF_FFFD, 32'd2, 32'd0, "cmp_m3_2");
        check("cmp1_E", {31'd0, flags_E}, 32'd0);
        check("cmp1_GT", {31'd0, flags_GT}, 32'd0);
        single(op(OP_CMP), 32'd5, 32'hFFFF_FFFF, 32'd0, "cmp_5_m1");
        check("cmp2_E", {31'd0, flags_E}, 32'd0);
        check("cmp2_GT", {31'd0, flags_GT}, 32'd1);
        single(op(OP_CMP), 32'd7, 32'd7, 32'd0, "cmp_7_7");
        check("cmp3_E", {31'd0, flags_E}, 32'd1);
        check("cmp3_GT", {31'd0, flags_GT}, 32'd0);
        single(op(OP_ADD), 32'd1, 32'd2, 32'd3, "add_after_cmp");
        check("flags_hold_E", {31'd0, flags_E}, 32'd1);
        check("flags_hold_GT", {31'd0, flags_GT}, 32'd0);
        bubble();

        div_op(op(OP_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        div_op(op(OP_MOD), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "mod_m7_2");
        bubble();
        div_op(op(OP_DIV), 32'd100, 32'd7, 32'd14, 33, "b2b_div1");
        div_op(op(OP_DIV), 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "b2b_div2");
        div_op(op(OP_DIV), 32'd10, 32'd0, 32'hFFFF_FFFF, 1, "div_10_0");
        div_op(op(OP_MOD), 32'd10, 32'd0, 32'd10, 1, "mod_10_0");
        div_op(op(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "div_min_m1");
        div_op(op(OP_MOD), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "mod_min_m1");
        div_op(op(OP_MOD), 32'd100, 32'hFFFF_FFF9, 32'd2, 33, "mod_100_m7");
        bubble();

        single(op(OP_CMP), 32'd4, 32'd4, 32'd0, "cmp_before_rst");
        valid_ALU = 1'b1; aluSignals_ALU = op(OP_DIV); A_ALU = 32'hFFFF_FFF9; B_ALU = 32'd2;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1; valid_ALU = 1'b0;
        @(negedge clk);
        check("midrst_stall_during", {31'd0, stall_OFALU}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_stall", {31'd0, stall_OFALU}, 32'd0);
        check("midrst_rv", {31'd0, res_valid}, 32'd0);
        check("midrst_flags_E", {31'd0, flags_E}, 32'd0);
        check("midrst_flags_GT", {31'd0, flags_GT}, 32'd0);
        @(posedge clk); #1;
        single(op(OP_ADD), 32'd1, 32'd1, 32'd2, "add_after_rst");
        bubble();
        bubble();

        check("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
